button_repeat: RTL and testbench

BUTTON_REPEAT -- requirements
Module: button_repeat

---
 rtl/button_repeat_pkg.sv | 19 +
 rtl/button_repeat_if.sv | 16 +
 rtl/button_repeat_repeat_timer.sv | 38 +++
 rtl/button_repeat.sv | 96 +++++++++
 tb/tb_button_repeat.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/button_repeat_pkg.sv
// button_repeat_pkg: shared FSM state codes and default tick values for the button/time-setting logic.
// Rev 1.0
`default_nettype none

package button_repeat_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam int DEF_DELAY_TICKS = 32;
  localparam int DEF_SLOW_TICKS  = 8;
  localparam int DEF_FAST_TICKS  = 2;
  localparam int DEF_ACCEL_COUNT = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

`default_nettype wire

// File: rtl/button_repeat_if.sv
// button_repeat_if: tick/button inputs and step-request outputs of the auto-repeat block.
// Rev 1.0
`default_nettype none

interface button_repeat_if;
  logic clk_en;
  logic button;
  logic pulse;
  logic held;
  logic fast;

  modport master (output clk_en, output button, input pulse, input held, input fast);
  modport slave  (input clk_en, input button, output pulse, output held, output fast);
endinterface

`default_nettype wire

// File: rtl/button_repeat_repeat_timer.sv
// repeat_timer: clk_en-gated tick counter with exact-equality terminal-count compare.
// Rev 1.0
`default_nettype none

module repeat_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_next;

  // Extra bit keeps the compare exact even when term is the all-ones value.
  assign w_next = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign hit    = inc && (w_next == {1'b0, term});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clk_en) begin
      if (clear) begin
        r_cnt <= '0;
      end else if (inc) begin
        r_cnt <= hit ? '0 : w_next[CNT_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_repeat.sv
// button_repeat: press/auto-repeat step generator with delayed start and accelerated repeat rate.
// Rev 1.0
`default_nettype none

module button_repeat
  import button_repeat_pkg::*;
#(
  parameter int DELAY_TICKS = DEF_DELAY_TICKS,
  parameter int SLOW_TICKS  = DEF_SLOW_TICKS,
  parameter int FAST_TICKS  = DEF_FAST_TICKS,
  parameter int ACCEL_COUNT = DEF_ACCEL_COUNT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  button_repeat_if.slave  bus
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_pulse;
  logic             w_fire;
  logic             w_accel;
  logic             w_hit;
  logic [CNT_W-1:0] w_term;

  assign w_accel = (r_rep_cnt >= CNT_W'(ACCEL_COUNT));
  assign w_term  = (r_state == ST_DELAY) ? CNT_W'(DELAY_TICKS)
                 : (w_accel ? CNT_W'(FAST_TICKS) : CNT_W'(SLOW_TICKS));

  repeat_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clk_en (bus.clk_en),
    .clear  ((r_state == ST_IDLE) || !bus.button),
    .inc    ((r_state != ST_IDLE) && bus.button),
    .term   (w_term),
    .hit    (w_hit)
  );

  // Release is checked before the terminal count so it always wins.
  always_comb begin
    w_state_nx = r_state;
    w_fire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.button) begin
          w_state_nx = ST_DELAY;
          w_fire     = 1'b1;
        end
      end
      ST_DELAY: begin
        if (!bus.button) begin
          w_state_nx = ST_IDLE;
        end else if (w_hit) begin
          w_state_nx = ST_REPEAT;
          w_fire     = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!bus.button) begin
          w_state_nx = ST_IDLE;
        end else if (w_hit) begin
          w_fire = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rep_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= bus.clk_en && w_fire;
      if (bus.clk_en) begin
        r_state <= w_state_nx;
        if ((w_state_nx == ST_IDLE) || (r_state == ST_IDLE)) begin
          r_rep_cnt <= '0;
        end else if ((r_state == ST_REPEAT) && w_fire && !w_accel) begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.pulse = r_pulse;
  assign bus.held  = (r_state != ST_IDLE);
  assign bus.fast  = (r_state == ST_REPEAT) && w_accel;

endmodule

`default_nettype wire

// File: tb/tb_button_repeat.sv
// tb_button_repeat: table vectors, corner sequences and random stimulus against a hold-time reference model.
// Rev 1.0
`default_nettype none

module tb_button_repeat;

  localparam int D = 4;
  localparam int S = 3;
  localparam int F = 1;
  localparam int A = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_repeat_if bus ();

  button_repeat #(
    .DELAY_TICKS (D),
    .SLOW_TICKS  (S),
    .FAST_TICKS  (F),
    .ACCEL_COUNT (A),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic en;
    logic btn;
    logic rst;
    logic p;
    logic h;
    logic f;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   k        = -1;   // ticks since press, -1 when not held
  logic m_pulse  = 1'b0;
  int   pulse_cnt;

  // Tick k after press is a step request if it is the press, the first repeat,
  // one of the A slow repeats, or any later fast repeat.
  function automatic bit sched(int kk);
    if (kk == 0) return 1'b1;
    if (kk < D) return 1'b0;
    if (kk <= D + A * S) return ((kk - D) % S) == 0;
    return ((kk - D - A * S) % F) == 0;
  endfunction

  task automatic chk(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic en, logic btn, logic rst);
    @(negedge clk);
    bus.clk_en = en;
    bus.button = btn;
    reset      = rst;
    @(posedge clk);
    #1;
    m_pulse = 1'b0;
    if (rst) begin
      k = -1;
    end else if (en) begin
      if (btn) begin
        k       = (k < 0) ? 0 : k + 1;
        m_pulse = sched(k);
      end else begin
        k = -1;
      end
    end
  endtask

  task automatic step_model(string name, logic en, logic btn, logic rst);
    drive(en, btn, rst);
    chk({name, ".pulse"}, bus.pulse, m_pulse);
    chk({name, ".held"}, bus.held, logic'(k >= 0));
    chk({name, ".fast"}, bus.fast, logic'(k >= D + A * S));
    if (bus.pulse === 1'b1) pulse_cnt++;
  endtask

  function automatic void add(logic en, logic btn, logic rst, logic p, logic h, logic f);
    vec_t v;
    v.en = en; v.btn = btn; v.rst = rst; v.p = p; v.h = h; v.f = f;
    vecs.push_back(v);
  endfunction

  initial begin
    bus.clk_en = 1'b0;
    bus.button = 1'b0;
    reset      = 1'b1;

    // Reset state, then 14-tick hold with the documented pulse ticks.
    add(0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++)
      add(1, 1, 0, logic'(i inside {0, 4, 7, 10, 11, 12, 13}), 1, logic'(i >= 10));
    add(1, 0, 0, 0, 0, 0);
    // Release at tick 2, re-press at tick 3.
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    // Glitches confined to clk_en-low cycles.
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    // Pulse is one clk wide even when clk_en is low in the following cycle.
    add(1, 1, 0, 1, 1, 0);
    add(0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].btn, vecs[i].rst);
      chk($sformatf("vec%0d.pulse", i), bus.pulse, vecs[i].p);
      chk($sformatf("vec%0d.held", i), bus.held, vecs[i].h);
      chk($sformatf("vec%0d.fast", i), bus.fast, vecs[i].f);
    end

    // Sparse clk_en: one tick in four, button held for 14 ticks.
    pulse_cnt = 0;
    step_model("sparse_rst", 1, 0, 1);
    for (int t = 0; t < 14; t++) begin
      step_model($sformatf("sparse_t%0d", t), 1, 1, 0);
      for (int j = 0; j < 3; j++) step_model($sformatf("sparse_t%0d_gap%0d", t, j), 0, 1, 0);
    end
    n_checks++;
    if (pulse_cnt != 7) begin
      n_err++;
      $display("FAIL sparse_pulse_count: got %0d expected 7", pulse_cnt);
    end
    step_model("sparse_rel", 1, 0, 0);

    // Reset mid-REPEAT with the button still held.
    for (int t = 0; t < 6; t++) step_model($sformatf("rr_t%0d", t), 1, 1, 0);
    chk("rr_in_repeat.held", bus.held, 1'b1);
    for (int t = 0; t < 2; t++) begin
      step_model($sformatf("rr_reset%0d", t), 1, 1, 1);
      chk("rr_reset.pulse0", bus.pulse, 1'b0);
      chk("rr_reset.held0", bus.held, 1'b0);
    end
    step_model("rr_repress", 1, 1, 0);
    chk("rr_repress.pulse1", bus.pulse, 1'b1);
    step_model("rr_rel", 1, 0, 0);

    // Random stimulus against the hold-time model.
    begin
      logic btn = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if (($urandom % 8) == 0) btn = ~btn;
        step_model("rand", logic'(($urandom % 4) != 0), btn, logic'(($urandom % 300) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
